fx3_slave_fifo_emulator: RTL and testbench
==========================================

# fx3_slave_fifo_emulator

Synthesizable model of the FX3 side of the synchronous Slave FIFO 2-bit interface. It answers the FPGA master's SLCS/SLWR/SLRD/SLOE/PKTEND/FADDR strobes, drives FLAGA..FLAGD, and sources or sinks the 32-bit data bus from two internal socket buffers. It sits in loopback and regression benches in place of the FX3 silicon. A host-side port preloads the transmit socket and drains the receive socket.

## Interface
- DATA_W, 32, data bus width
- DEPTH, 256, words per socket buffer (power of 2, ≥16)
- WMARK, 6, partial-flag watermark in words (covers master flag-pipeline overshoot)
- clk  in  1  interface clock (the master's clk_out), all logic on rising edge
- reset  in  1  synchronous, active-high
- slcs, slwr, slrd, sloe, pktend  in  1 each  active-low master strobes
- faddr  in  2  socket select: 2'b00 = RX socket (master writes), 2'b11 = TX socket (master reads)
- fdata_i  in  DATA_W  bus value driven by master
- fdata_o  out  DATA_W  bus value driven by emulator
- fdata_oe  out  1  emulator drives bus when 1 (bench resolves inout)
- flaga, flagb  out  1  RX full (active-low) / RX partial-full (active-low)
- flagc, flagd  out  1  TX empty (active-low) / TX partial-empty (active-low)
- host_tx_wr  in  1, host_tx_data  in  DATA_W, host_tx_full  out  1  preload TX socket
- host_rx_rd  in  1, host_rx_data  out  DATA_W, host_rx_valid  out  1, host_rx_empty  out  1  drain RX socket
- pkt_cnt  out  16  count of sampled PKTEND strobes, wraps
- err  out  4  sticky error bits

## Operation
- All strobes are qualified by slcs==0. With slcs==1 the emulator ignores slwr, slrd, sloe and pktend.
- Master write: on a rising edge with slwr==0 and faddr==00, fdata_i is pushed into RX. If RX is full, the word is dropped and err[0] is set.
- Master read: on an edge with slrd==0 and faddr==11, one TX word is popped into a 2-stage output pipeline. If TX is empty, 0 enters the pipeline and err[1] is set.
- Bad address: slwr==0 with faddr≠00, or slrd==0 with faddr≠11, sets err[2]. No buffer change occurs.
- Strobe collision: slwr==0 and slrd==0 in the same cycle sets err[3]. Neither operation happens.
- PKTEND: pktend==0 increments pkt_cnt, wrapping at 16'hFFFF→0. It does not alter buffer contents.
- Host TX push:
  - host_tx_wr with TX not full pushes host_tx_data.
  - A push while full is ignored, with no error bit.
- Host RX pop:
  - host_rx_rd with RX not empty pops one word.
  - host_rx_data is registered and valid with host_rx_valid=1 on the next cycle.
  - A pop while empty produces no valid.
- Simultaneous push and pop on the same socket both take effect; the count is unchanged. Occupancy counts are clog2(DEPTH)+1 bits wide, and pointers wrap modulo DEPTH.
- Flag definitions (registered from post-operation counts):
  - flaga = (rx_cnt != DEPTH)
  - flagb = (DEPTH − rx_cnt > WMARK)
  - flagc = (tx_cnt != 0)
  - flagd = (tx_cnt > WMARK)
- err bits are sticky and cleared only by reset.

## Timing
- Reset values:
  - Buffers: counts 0, pointers 0.
  - Flags: flaga=1, flagb=1, flagc=0, flagd=0.
  - Outputs: fdata_o=0, fdata_oe=0, host_rx_valid=0, host_rx_data=0, pkt_cnt=0, err=0.
  - Host-side status: host_tx_full=0, host_rx_empty=1.
- Reset asserted mid-transfer discards all buffer contents and in-flight pipeline data on that edge.
- Read latency: slrd sampled low at edge N gives the word on fdata_o after edge N+2. A continuous slrd burst yields one word per cycle.
- fdata_oe = registered (slcs==0 && sloe==0 && faddr==11). It rises one cycle after sloe is sampled low and falls one cycle after sloe is sampled high.
- fdata_o holds its last value while no read is in the pipeline.
- Flag latency: a push or pop at edge N is reflected in flags after edge N. The master sees it one further cycle later via its own flop.
- host_tx_full and host_rx_empty are combinational from the current counts.
- The buffer accepts a write on the exact edge a read frees space. Full/empty are evaluated on pre-edge counts plus same-edge opposite operation.

## Test plan
- Reset, then idle → flaga=1, flagb=1, flagc=0, flagd=0, fdata_oe=0, err=4'h0.
- Host preloads 16 words 0x1000..0x100F. Master reads 16 back-to-back with sloe low → fdata_o shows 0x1000..0x100F starting 2 cycles after the first slrd. flagd falls when tx_cnt≤6, flagc falls after the last pop, err=0.
- Master writes DEPTH+2 words 0..257 at faddr=00 → flagb=0 once free≤6, flaga=0 at 256. Words 256 and 257 are dropped, err[0]=1. Host drains 0..255 in order.
- Master read with TX empty → fdata_o=0 two cycles later, err[1]=1. Then slwr low at faddr=11 → err[2]=1, RX unchanged.
- Same-cycle host push and master pop on TX with tx_cnt=5 → tx_cnt stays 5. Then slwr and slrd both low → err[3]=1, no counts change.
- pktend low for 3 cycles with slcs=0, then 1 cycle with slcs=1 → pkt_cnt=3. Reset asserted mid-burst → all counts and flags return to reset values next cycle.

Source files
------------

// File: rtl/fx3_slave_fifo_emulator.sv
// FX3-side model of the synchronous Slave FIFO interface: RX/TX socket buffers,
// registered flags, a 2-stage read pipeline and sticky protocol error bits.
module fx3_slave_fifo_emulator #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int WMARK  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slcs,
    input  logic              slwr,
    input  logic              slrd,
    input  logic              sloe,
    input  logic              pktend,
    input  logic [1:0]        faddr,
    input  logic [DATA_W-1:0] fdata_i,
    output logic [DATA_W-1:0] fdata_o,
    output logic              fdata_oe,
    output logic              flaga,
    output logic              flagb,
    output logic              flagc,
    output logic              flagd,
    input  logic              host_tx_wr,
    input  logic [DATA_W-1:0] host_tx_data,
    output logic              host_tx_full,
    input  logic              host_rx_rd,
    output logic [DATA_W-1:0] host_rx_data,
    output logic              host_rx_valid,
    output logic              host_rx_empty,
    output logic [15:0]       pkt_cnt,
    output logic [3:0]        err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] WMARK_C = CNT_W'(WMARK);

    logic [DATA_W-1:0] rx_mem [DEPTH];
    logic [DATA_W-1:0] tx_mem [DEPTH];

    logic [PTR_W-1:0]  rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
    logic [CNT_W-1:0]  rx_cnt_q, tx_cnt_q, rx_cnt_d, tx_cnt_d;
    logic              flaga_q, flagb_q, flagc_q, flagd_q;
    logic              vld_p0_q, vld_p1_q;
    logic [DATA_W-1:0] rd_data_p0_q, rd_data_p1_q;
    logic [DATA_W-1:0] fdata_o_q, host_rx_data_q;
    logic              fdata_oe_q, host_rx_valid_q;
    logic [15:0]       pkt_cnt_q;
    logic [3:0]        err_q, err_set;

    logic              cs, m_wr, m_rd, collide;
    logic              rx_wr_req, tx_rd_req;
    logic              rx_push, rx_pop, tx_push, tx_pop;
    logic [DATA_W-1:0] rx_pop_data, tx_pop_data;

    // Full/empty use pre-edge counts, relaxed by the same-edge opposite operation.
    always_comb begin
        cs          = !slcs;
        m_wr        = cs && !slwr;
        m_rd        = cs && !slrd;
        collide     = m_wr && m_rd;
        rx_wr_req   = m_wr && !m_rd && (faddr == 2'b00);
        tx_rd_req   = m_rd && !m_wr && (faddr == 2'b11);
        rx_push     = rx_wr_req && ((rx_cnt_q != FULL_C) || host_rx_rd);
        rx_pop      = host_rx_rd && ((rx_cnt_q != '0) || rx_wr_req);
        tx_push     = host_tx_wr && ((tx_cnt_q != FULL_C) || tx_rd_req);
        tx_pop      = tx_rd_req && ((tx_cnt_q != '0) || host_tx_wr);
        rx_pop_data = (rx_cnt_q == '0) ? fdata_i : rx_mem[rx_rp_q];
        tx_pop_data = (tx_cnt_q == '0) ? host_tx_data : tx_mem[tx_rp_q];
        rx_cnt_d    = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
        tx_cnt_d    = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
        err_set[0]  = rx_wr_req && !rx_push;
        err_set[1]  = tx_rd_req && !tx_pop;
        err_set[2]  = !collide && ((m_wr && faddr != 2'b00) || (m_rd && faddr != 2'b11));
        err_set[3]  = collide;
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp_q] <= fdata_i;
        if (tx_push) tx_mem[tx_wp_q] <= host_tx_data;
    end

    // Read pipeline data path; validity is tracked alongside in the control block.
    always_ff @(posedge clk) begin
        rd_data_p0_q <= tx_pop ? tx_pop_data : '0;
        rd_data_p1_q <= rd_data_p0_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp_q         <= '0;
            rx_rp_q         <= '0;
            tx_wp_q         <= '0;
            tx_rp_q         <= '0;
            rx_cnt_q        <= '0;
            tx_cnt_q        <= '0;
            flaga_q         <= 1'b1;
            flagb_q         <= 1'b1;
            flagc_q         <= 1'b0;
            flagd_q         <= 1'b0;
            vld_p0_q        <= 1'b0;
            vld_p1_q        <= 1'b0;
            fdata_o_q       <= '0;
            fdata_oe_q      <= 1'b0;
            host_rx_data_q  <= '0;
            host_rx_valid_q <= 1'b0;
            pkt_cnt_q       <= '0;
            err_q           <= '0;
        end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + PTR_W'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + PTR_W'(1);
            if (tx_push) tx_wp_q <= tx_wp_q + PTR_W'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + PTR_W'(1);
            rx_cnt_q        <= rx_cnt_d;
            tx_cnt_q        <= tx_cnt_d;
            flaga_q         <= (rx_cnt_d != FULL_C);
            flagb_q         <= ((FULL_C - rx_cnt_d) > WMARK_C);
            flagc_q         <= (tx_cnt_d != '0);
            flagd_q         <= (tx_cnt_d > WMARK_C);
            vld_p0_q        <= tx_rd_req;
            vld_p1_q        <= vld_p0_q;
            if (vld_p1_q) fdata_o_q <= rd_data_p1_q;
            fdata_oe_q      <= cs && !sloe && (faddr == 2'b11);
            host_rx_valid_q <= rx_pop;
            if (rx_pop) host_rx_data_q <= rx_pop_data;
            if (cs && !pktend) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            err_q           <= err_q | err_set;
        end
    end

    assign fdata_o       = fdata_o_q;
    assign fdata_oe      = fdata_oe_q;
    assign flaga         = flaga_q;
    assign flagb         = flagb_q;
    assign flagc         = flagc_q;
    assign flagd         = flagd_q;
    assign host_tx_full  = (tx_cnt_q == FULL_C);
    assign host_rx_empty = (rx_cnt_q == '0);
    assign host_rx_data  = host_rx_data_q;
    assign host_rx_valid = host_rx_valid_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign err           = err_q;
endmodule

// File: tb/tb_fx3_slave_fifo_emulator.sv
// Bench for fx3_slave_fifo_emulator: directed scenarios plus a randomized run,
// all checked against a queue-based model of the two sockets.
module tb_fx3_slave_fifo_emulator;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int WMARK  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, slcs, slwr, slrd, sloe, pktend;
    logic [1:0]        faddr;
    logic [DATA_W-1:0] fdata_i, fdata_o, host_tx_data, host_rx_data;
    logic              fdata_oe, flaga, flagb, flagc, flagd;
    logic              host_tx_wr, host_tx_full, host_rx_rd, host_rx_valid, host_rx_empty;
    logic [15:0]       pkt_cnt;
    logic [3:0]        err;

    fx3_slave_fifo_emulator #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WMARK(WMARK)) dut (
        .clk(clk), .reset(reset), .slcs(slcs), .slwr(slwr), .slrd(slrd), .sloe(sloe),
        .pktend(pktend), .faddr(faddr), .fdata_i(fdata_i), .fdata_o(fdata_o),
        .fdata_oe(fdata_oe), .flaga(flaga), .flagb(flagb), .flagc(flagc), .flagd(flagd),
        .host_tx_wr(host_tx_wr), .host_tx_data(host_tx_data), .host_tx_full(host_tx_full),
        .host_rx_rd(host_rx_rd), .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid),
        .host_rx_empty(host_rx_empty), .pkt_cnt(pkt_cnt), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: sockets as queues, read results scheduled by edge number.
    logic [DATA_W-1:0] rxq[$];
    logic [DATA_W-1:0] txq[$];
    logic [DATA_W-1:0] due[int];
    int                edge_n = 0;
    logic [DATA_W-1:0] m_fdata = '0, m_hrx_data = '0;
    logic              m_oe = 1'b0, m_hrx_valid = 1'b0;
    logic [15:0]       m_pkt = '0;
    logic [3:0]        m_err = '0;

    function automatic logic e_fa(); return rxq.size() != DEPTH; endfunction
    function automatic logic e_fb(); return (DEPTH - rxq.size()) > WMARK; endfunction
    function automatic logic e_fc(); return txq.size() != 0; endfunction
    function automatic logic e_fd(); return txq.size() > WMARK; endfunction

    function automatic void model_edge();
        bit cs, wr, rd, rx_acc, tx_req, hpush, hpop;
        logic [DATA_W-1:0] v;
        if (reset) begin
            rxq.delete(); txq.delete(); due.delete();
            m_fdata = '0; m_oe = 1'b0; m_hrx_data = '0; m_hrx_valid = 1'b0;
            m_pkt = '0; m_err = '0;
            return;
        end
        if (due.exists(edge_n)) begin
            m_fdata = due[edge_n];
            due.delete(edge_n);
        end
        cs = !slcs; wr = cs && !slwr; rd = cs && !slrd;
        rx_acc = 0; tx_req = 0;
        if (wr && rd) m_err[3] = 1'b1;
        else begin
            if (wr) begin
                if (faddr != 2'b00) m_err[2] = 1'b1;
                else if (rxq.size() < DEPTH || host_rx_rd) rx_acc = 1;
                else m_err[0] = 1'b1;
            end
            if (rd) begin
                if (faddr == 2'b11) tx_req = 1;
                else m_err[2] = 1'b1;
            end
        end
        hpush = host_tx_wr && (txq.size() < DEPTH || tx_req);
        hpop  = host_rx_rd && (rxq.size() > 0 || rx_acc);
        if (hpush) txq.push_back(host_tx_data);
        if (tx_req) begin
            if (txq.size() > 0) v = txq.pop_front();
            else begin v = '0; m_err[1] = 1'b1; end
            due[edge_n + 2] = v;
        end
        if (rx_acc) rxq.push_back(fdata_i);
        m_hrx_valid = hpop;
        if (hpop) m_hrx_data = rxq.pop_front();
        if (cs && !pktend) m_pkt = m_pkt + 16'd1;
        m_oe = cs && !sloe && (faddr == 2'b11);
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic idle_inputs();
        slcs = 1; slwr = 1; slrd = 1; sloe = 1; pktend = 1; faddr = 2'b00;
        fdata_i = '0; host_tx_wr = 0; host_tx_data = '0; host_rx_rd = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; step(); step();
        reset = 0; step();
        n_cmp++; if ({flaga, flagb, flagc, flagd} !== 4'b1100) begin n_bad++; $display("FAIL reset_flags got %b want 1100", {flaga, flagb, flagc, flagd}); end
        n_cmp++; if (fdata_oe !== 1'b0 || fdata_o !== '0) begin n_bad++; $display("FAIL reset_bus got oe=%b d=%h want 0/0", fdata_oe, fdata_o); end
        n_cmp++; if (err !== 4'h0 || pkt_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_err_pkt got %h/%h want 0/0", err, pkt_cnt); end
        n_cmp++; if ({host_tx_full, host_rx_empty, host_rx_valid} !== 3'b010) begin n_bad++; $display("FAIL reset_host got %b want 010", {host_tx_full, host_rx_empty, host_rx_valid}); end
    endtask

    task automatic test_tx_burst();
        for (int i = 0; i < 16; i++) begin host_tx_wr = 1; host_tx_data = 32'h1000 + i; step(); end
        host_tx_wr = 0; slcs = 0; sloe = 0; faddr = 2'b11; step();
        n_cmp++; if (fdata_oe !== 1'b1) begin n_bad++; $display("FAIL burst_oe got %b want 1", fdata_oe); end
        for (int i = 0; i < 20; i++) begin
            slrd = (i < 16) ? 1'b0 : 1'b1;
            step();
            n_cmp++; if (fdata_o !== m_fdata) begin n_bad++; $display("FAIL burst_data cyc %0d got %h want %h", i, fdata_o, m_fdata); end
            n_cmp++; if ({flagc, flagd} !== {e_fc(), e_fd()}) begin n_bad++; $display("FAIL burst_flags cyc %0d got %b want %b", i, {flagc, flagd}, {e_fc(), e_fd()}); end
            if (i >= 2 && i < 18) begin
                n_cmp++; if (fdata_o !== 32'h1000 + i - 2) begin n_bad++; $display("FAIL burst_seq cyc %0d got %h want %h", i, fdata_o, 32'h1000 + i - 2); end
            end
        end
        sloe = 1; slcs = 1; step();
        n_cmp++; if (fdata_oe !== 1'b0 || err !== 4'h0 || flagc !== 1'b0) begin n_bad++; $display("FAIL burst_end got oe=%b err=%h flagc=%b want 0/0/0", fdata_oe, err, flagc); end
    endtask

    task automatic test_rx_fill();
        slcs = 0; slwr = 0; faddr = 2'b00;
        for (int i = 0; i < DEPTH + 2; i++) begin
            fdata_i = i;
            step();
            n_cmp++; if ({flaga, flagb} !== {e_fa(), e_fb()}) begin n_bad++; $display("FAIL fill_flags word %0d got %b want %b", i, {flaga, flagb}, {e_fa(), e_fb()}); end
        end
        slwr = 1; slcs = 1; step();
        n_cmp++; if (flaga !== 1'b0 || flagb !== 1'b0 || err !== 4'h1) begin n_bad++; $display("FAIL fill_full got a=%b b=%b err=%h want 0/0/1", flaga, flagb, err); end
        for (int i = 0; i < DEPTH; i++) begin
            host_rx_rd = 1;
            step();
            n_cmp++; if (host_rx_valid !== 1'b1 || host_rx_data !== i) begin n_bad++; $display("FAIL drain word %0d got v=%b d=%h want 1/%h", i, host_rx_valid, host_rx_data, i); end
        end
        host_rx_rd = 0; step();
        n_cmp++; if (host_rx_valid !== 1'b0 || host_rx_empty !== 1'b1 || {flaga, flagb} !== 2'b11) begin n_bad++; $display("FAIL drain_end got v=%b e=%b ab=%b want 0/1/11", host_rx_valid, host_rx_empty, {flaga, flagb}); end
    endtask

    task automatic test_errors();
        slcs = 0; slrd = 0; faddr = 2'b11; step();
        slrd = 1; step(); step();
        n_cmp++; if (fdata_o !== '0 || err[1] !== 1'b1) begin n_bad++; $display("FAIL empty_read got d=%h err=%h want 0/err1", fdata_o, err); end
        slwr = 0; faddr = 2'b11; step();
        slwr = 1; slcs = 1; step();
        n_cmp++; if (err[2] !== 1'b1 || host_rx_empty !== 1'b1 || err[3] !== 1'b0) begin n_bad++; $display("FAIL bad_addr got err=%h rx_empty=%b want err2 set/1", err, host_rx_empty); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin host_tx_wr = 1; host_tx_data = 32'hA0 + i; step(); end
        host_tx_data = 32'hA5; slcs = 0; slrd = 0; faddr = 2'b11; step();
        slrd = 1; slcs = 1; host_tx_data = 32'hA6; step();
        n_cmp++; if (flagd !== 1'b0 || flagc !== 1'b1) begin n_bad++; $display("FAIL simul_cnt6 got c=%b d=%b want 1/0", flagc, flagd); end
        host_tx_data = 32'hA7; step();
        n_cmp++; if (flagd !== 1'b1 || fdata_o !== 32'hA0 || fdata_o !== m_fdata) begin n_bad++; $display("FAIL simul_cnt7 got d=%b data=%h want 1/a0", flagd, fdata_o); end
        host_tx_wr = 0; slcs = 0; slwr = 0; slrd = 0; step();
        slwr = 1; slrd = 1; slcs = 1; step();
        n_cmp++; if (err[3] !== 1'b1 || {flagc, flagd} !== 2'b11 || host_rx_empty !== 1'b1) begin n_bad++; $display("FAIL collide got err=%h cd=%b rx_empty=%b want err3/11/1", err, {flagc, flagd}, host_rx_empty); end
        n_cmp++; if (err !== m_err || fdata_o !== m_fdata) begin n_bad++; $display("FAIL collide_model got err=%h d=%h want %h/%h", err, fdata_o, m_err, m_fdata); end
    endtask

    task automatic test_pktend_reset();
        reset = 1; step(); reset = 0;
        slcs = 0; pktend = 0; step(); step(); step();
        slcs = 1; step();
        pktend = 1; step();
        n_cmp++; if (pkt_cnt !== 16'd3) begin n_bad++; $display("FAIL pktend got %0d want 3", pkt_cnt); end
        for (int i = 0; i < 4; i++) begin host_tx_wr = 1; host_tx_data = 32'hBEEF0 + i; step(); end
        host_tx_wr = 0; slcs = 0; sloe = 0; faddr = 2'b11; slrd = 0; step(); step();
        reset = 1; step();
        n_cmp++; if ({flaga, flagb, flagc, flagd} !== 4'b1100 || fdata_oe !== 1'b0) begin n_bad++; $display("FAIL midreset_flags got %b oe=%b want 1100/0", {flaga, flagb, flagc, flagd}, fdata_oe); end
        n_cmp++; if (err !== 4'h0 || pkt_cnt !== 16'h0 || host_rx_empty !== 1'b1 || host_tx_full !== 1'b0) begin n_bad++; $display("FAIL midreset_state got err=%h pkt=%0d want 0/0", err, pkt_cnt); end
        idle_inputs(); reset = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (fdata_o !== '0) begin n_bad++; $display("FAIL midreset_flush cyc %0d got %h want 0", i, fdata_o); end
        end
    endtask

    task automatic test_random();
        int r;
        idle_inputs();
        reset = 1; step(); reset = 0;
        for (int i = 0; i < 1600; i++) begin
            bit wphase;
            wphase = (i < 800);
            slcs = ($urandom % 8 == 0);
            r = $urandom % 16;
            faddr = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : ($urandom % 2 ? 2'b11 : 2'b00);
            slwr = ($urandom % 4 < (wphase ? 3 : 1)) ? 1'b0 : 1'b1;
            slrd = ($urandom % 4 < (wphase ? 1 : 3)) ? 1'b0 : 1'b1;
            if (!slwr && !slrd && ($urandom % 4 != 0)) begin
                if (wphase) slrd = 1; else slwr = 1;
            end
            if (!slwr) faddr = ($urandom % 10 == 0) ? faddr : 2'b00;
            if (!slrd) faddr = ($urandom % 10 == 0) ? faddr : 2'b11;
            sloe = $urandom % 2;
            pktend = ($urandom % 5 != 0);
            fdata_i = $urandom;
            host_tx_wr = ($urandom % 4 < (wphase ? 3 : 1));
            host_tx_data = $urandom;
            host_rx_rd = ($urandom % 8 < (wphase ? 1 : 6));
            step();
            n_cmp++; if (fdata_o !== m_fdata || fdata_oe !== m_oe) begin n_bad++; $display("FAIL rnd_bus cyc %0d got %h/%b want %h/%b", i, fdata_o, fdata_oe, m_fdata, m_oe); end
            n_cmp++; if ({flaga, flagb, flagc, flagd} !== {e_fa(), e_fb(), e_fc(), e_fd()}) begin n_bad++; $display("FAIL rnd_flags cyc %0d got %b want %b", i, {flaga, flagb, flagc, flagd}, {e_fa(), e_fb(), e_fc(), e_fd()}); end
            n_cmp++; if (host_tx_full !== (txq.size() == DEPTH) || host_rx_empty !== (rxq.size() == 0)) begin n_bad++; $display("FAIL rnd_status cyc %0d got %b%b want %b%b", i, host_tx_full, host_rx_empty, txq.size() == DEPTH, rxq.size() == 0); end
            n_cmp++; if (host_rx_valid !== m_hrx_valid || host_rx_data !== m_hrx_data) begin n_bad++; $display("FAIL rnd_host_rx cyc %0d got %b/%h want %b/%h", i, host_rx_valid, host_rx_data, m_hrx_valid, m_hrx_data); end
            n_cmp++; if (pkt_cnt !== m_pkt || err !== m_err) begin n_bad++; $display("FAIL rnd_pkt_err cyc %0d got %0d/%h want %0d/%h", i, pkt_cnt, err, m_pkt, m_err); end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_tx_burst();
        test_rx_fill();
        test_errors();
        test_back_to_back();
        test_pktend_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
